lcd_bus_driver: RTL

- Parametrised HD44780-class text-LCD write engine; successor to the fixed 8-bit LCD strobe controller.
- Adds selectable 4-bit/8-bit bus mode, parametrised setup/E-pulse/hold timing, and a built-in command execution wait (normal and long), so the host needs no delay counters.
- Sits between the LCD init/text sequencer (host, valid/ready) and the LCD pins.

---
 rtl/lcd_bus_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lcd_bus_driver.sv
// HD44780-class write engine: turns one accepted host byte into timed RS/data/E
// activity on the LCD pins (4- or 8-bit bus), then waits out the controller's execution time.
`timescale 1ns/1ps
module lcd_bus_driver #(
  parameter bit BUS4          = 1'b0,
  parameter int SETUP_CLK     = 3,
  parameter int PW_E_CLK      = 12,
  parameter int HOLD_CLK      = 1,
  parameter int GAP_CLK       = 50,
  parameter int EXEC_CLK      = 2000,
  parameter int LONG_EXEC_CLK = 82000,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_data
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP, EXEC} state_t;

  // Each phase loads N-1 on entry and leaves when the counter reads zero.
  localparam logic [CNT_W-1:0] SETUP_N = CNT_W'(SETUP_CLK - 1);
  localparam logic [CNT_W-1:0] PULSE_N = CNT_W'(PW_E_CLK - 1);
  localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_CLK - 1);
  localparam logic [CNT_W-1:0] GAP_N   = CNT_W'(GAP_CLK - 1);
  localparam logic [CNT_W-1:0] EXEC_N  = CNT_W'(EXEC_CLK - 1);
  localparam logic [CNT_W-1:0] LONG_N  = CNT_W'(LONG_EXEC_CLK - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       data_q, data_d;
  logic             phase_q, phase_d;
  logic             long_q, long_d;
  logic             e_q, e_d;
  logic             done_q, done_d;

  function automatic logic [7:0] drive_word(input logic [7:0] b, input logic ph);
    if (!BUS4) return b;
    return ph ? {b[3:0], 4'b0000} : {b[7:4], 4'b0000};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      byte_q  <= 8'h00;
      data_q  <= 8'h00;
      phase_q <= 1'b0;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      phase_q <= phase_d;
      long_q  <= long_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    byte_d  = byte_q;
    data_d  = data_q;
    phase_d = phase_q;
    long_d  = long_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SETUP;
          cnt_d   = SETUP_N;
          rs_d    = in_rs;
          byte_d  = in_data;
          phase_d = 1'b0;
          // Clear (0x01) and home (0x02/0x03) need the long execution wait.
          long_d  = !in_rs && (in_data[7:2] == 6'd0) && (in_data != 8'h00);
          data_d  = drive_word(in_data, 1'b0);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = PULSE_N;
        end else cnt_d = cnt_q - ONE;
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_N;
        end else cnt_d = cnt_q - ONE;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (BUS4 && !phase_q) begin
            state_d = GAP;
            cnt_d   = GAP_N;
          end else begin
            state_d = EXEC;
            cnt_d   = long_q ? LONG_N : EXEC_N;
          end
        end else cnt_d = cnt_q - ONE;
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = SETUP;
          cnt_d   = SETUP_N;
          phase_d = 1'b1;
          data_d  = drive_word(byte_q, 1'b1);
        end else cnt_d = cnt_q - ONE;
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else cnt_d = cnt_q - ONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    e_d = (state_d == PULSE);
  end

  always_comb begin
    in_ready = (state_q == IDLE) && !reset;
    busy     = !in_ready;
    done     = done_q;
    LCD_RS   = rs_q;
    LCD_RW   = 1'b0;
    LCD_E    = e_q;
    LCD_data = data_q;
  end

endmodule
